// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_pkg
// Description : Shared constants and helpers for the led_ctrl switch-to-LED
//               controller: output mode encodings and a counter-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_PASS   = 2'd0;
    localparam mode_t MODE_TOGGLE = 2'd1;
    localparam mode_t MODE_BLINK  = 2'd2;
    localparam mode_t MODE_OR     = 2'd3;

    // Bits needed to hold 0..v-1, never less than one bit so that a
    // terminal count of 1 still yields a legal vector.
    function automatic int min1_clog2(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_if.sv
`default_nettype none
// ============================================================================
// Module      : led_if
// Description : Board-side bundle of led_ctrl: raw switches and mode select
//               in, LED drive, OR-of-switches and press pulses out.
//               master = board/bench side, slave = led_ctrl.
// Ports       : sw[N], mode[2] (master->slave); led[N], any, press[N]
//               (slave->master)
// Revision    : 1.0 - initial release
// ============================================================================
interface led_if #(
    parameter int N = 4
);
    logic [N-1:0] sw;
    logic [1:0]   mode;
    logic [N-1:0] led;
    logic         any;
    logic [N-1:0] press;

    modport master (output sw, output mode, input led, input any, input press);
    modport slave  (input sw, input mode, output led, output any, output press);
endinterface
`default_nettype wire

// File: rtl/sw_debounce.sv
`default_nettype none
// ============================================================================
// Module      : sw_debounce
// Description : One switch channel: 2-FF synchroniser, stability counter and
//               debounced state, plus a one-cycle pulse on an accepted rise.
// Ports       : clk, rst (async, active-high), sw (raw, asynchronous),
//               db (debounced level), press (one-cycle rising-commit pulse)
// Revision    : 1.0 - initial release
// ============================================================================
module sw_debounce
    import led_pkg::*;
#(
    parameter int DB_CYCLES = 320000
) (
    input  logic clk,
    input  logic rst,
    input  logic sw,
    output logic db,
    output logic press
);

    localparam int             CW        = min1_clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0]  C_DB_LAST = CW'(DB_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_db;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_db    <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= sw;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_db) begin
                // Any sample agreeing with the accepted level restarts the
                // qualification window, so short glitches never commit.
                r_cnt <= '0;
            end else if (r_cnt == C_DB_LAST) begin
                r_db    <= r_sync2;
                r_cnt   <= '0;
                r_press <= r_sync2;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign db    = r_db;
    assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/led_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : led_ctrl
// Description : N-channel switch-to-LED controller. Each switch is
//               synchronised and debounced; LEDs show the debounced level,
//               a per-channel toggle state, a blinking debounced level, or
//               the OR of all channels, selected at run time by mode.
// Ports       : clk, rst (async, active-high)
//               bus (led_if.slave): sw[N] raw switches, mode[2] select,
//               led[N] registered LED drive, any registered OR of debounced
//               switches, press[N] one-cycle accepted-rise pulses
// Revision    : 1.0 - initial release
// ============================================================================
module led_ctrl
    import led_pkg::*;
#(
    parameter int N         = 4,
    parameter int DB_CYCLES = 320000,
    parameter int BLINK_DIV = 4000000
) (
    input  logic   clk,
    input  logic   rst,
    led_if.slave   bus
);

    localparam int            BW           = min1_clog2(BLINK_DIV);
    localparam logic [BW-1:0] C_BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [N-1:0]  w_db;
    logic [N-1:0]  w_press;
    logic [N-1:0]  w_tog;
    logic [N-1:0]  w_led_next;

    logic [N-1:0]  r_tog;
    logic [BW-1:0] r_bcnt;
    logic          r_phase;
    logic [N-1:0]  r_led;
    logic          r_any;

    for (genvar i = 0; i < N; i++) begin : g_ch
        sw_debounce #(
            .DB_CYCLES (DB_CYCLES)
        ) u_db (
            .clk   (clk),
            .rst   (rst),
            .sw    (bus.sw[i]),
            .db    (w_db[i]),
            .press (w_press[i])
        );
    end

    // press is already a register set on the commit edge, so r_tog ^ press
    // presents the toggle state as if it had flipped on that same edge;
    // r_tog then absorbs the flip one cycle later, leaving w_tog unchanged.
    assign w_tog = r_tog ^ w_press;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tog <= '0;
        end else begin
            r_tog <= w_tog;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bcnt  <= '0;
            r_phase <= 1'b0;
        end else if (r_bcnt == C_BLINK_LAST) begin
            r_bcnt  <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_bcnt <= r_bcnt + BW'(1);
        end
    end

    always_comb begin
        w_led_next = '0;
        case (bus.mode)
            MODE_PASS:   w_led_next = w_db;
            MODE_TOGGLE: w_led_next = w_tog;
            MODE_BLINK:  w_led_next = w_db & {N{r_phase}};
            MODE_OR:     w_led_next = {N{|w_db}};
            default:     w_led_next = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_led <= '0;
            r_any <= 1'b0;
        end else begin
            r_led <= w_led_next;
            r_any <= |w_db;
        end
    end

    assign bus.led   = r_led;
    assign bus.any   = r_any;
    assign bus.press = w_press;

endmodule
`default_nettype wire

// File: tb/tb_led_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_ctrl
// Description : Self-checking bench for led_ctrl with N=4, DB_CYCLES=4,
//               BLINK_DIV=3. Expected led/any/press per clock edge are
//               queued as stimulus is applied and popped one per edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_ctrl;

    localparam int N         = 4;
    localparam int DB_CYCLES = 4;
    localparam int BLINK_DIV = 3;

    typedef struct {
        string      tag;
        logic [3:0] led;
        logic       any;
        logic [3:0] press;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    exp_t sb[$];

    led_if #(.N(N)) bus ();

    led_ctrl #(
        .N         (N),
        .DB_CYCLES (DB_CYCLES),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic push_n(input string tag, input int n, input logic [3:0] l,
                          input logic a, input logic [3:0] p);
        exp_t e;
        e.tag   = tag;
        e.led   = l;
        e.any   = a;
        e.press = p;
        for (int i = 0; i < n; i++) sb.push_back(e);
    endtask

    task automatic compare(input exp_t e);
        n_checks++;
        assert (bus.led === e.led) else begin
            n_fail++;
            $error("FAIL %s led=%b expected=%b", e.tag, bus.led, e.led);
        end
        n_checks++;
        assert (bus.any === e.any) else begin
            n_fail++;
            $error("FAIL %s any=%b expected=%b", e.tag, bus.any, e.any);
        end
        n_checks++;
        assert (bus.press === e.press) else begin
            n_fail++;
            $error("FAIL %s press=%b expected=%b", e.tag, bus.press, e.press);
        end
    endtask

    // One clock edge per queued entry; sample 1 time unit after the edge.
    task automatic drain();
        exp_t e;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            @(posedge clk);
            #1;
            compare(e);
        end
    endtask

    task automatic check_now(input string tag, input logic [3:0] l,
                             input logic a, input logic [3:0] p);
        push_n(tag, 1, l, a, p);
        compare(sb.pop_front());
    endtask

    // Assert reset between edges, verify outputs clear without a clock edge,
    // hold through one edge, release just after the next edge.
    task automatic reset_pulse(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check_now(tag, 4'b0000, 1'b0, 4'b0000);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int ph;
        logic dbp;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        bus.sw   = 4'b0000;
        bus.mode = 2'd0;

        // Power-on reset
        #2;
        rst = 1'b1;
        #1;
        check_now("por", 4'b0000, 1'b0, 4'b0000);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // All switches high for 20 cycles: simultaneous commits
        bus.sw = 4'b1111;
        push_n("hold_wait",  5, 4'b0000, 1'b0, 4'b0000);
        push_n("hold_press", 1, 4'b0000, 1'b0, 4'b1111);
        push_n("hold_led",  14, 4'b1111, 1'b1, 4'b0000);
        drain();

        // Async reset with switches held: must requalify from scratch
        reset_pulse("rst_async");
        push_n("req_wait",  5, 4'b0000, 1'b0, 4'b0000);
        push_n("req_press", 1, 4'b0000, 1'b0, 4'b1111);
        push_n("req_led",   2, 4'b1111, 1'b1, 4'b0000);
        drain();

        // PASS: release all, then single rise on sw[0]
        bus.sw = 4'b0000;
        push_n("pass_fall", 6, 4'b1111, 1'b1, 4'b0000);
        push_n("pass_off",  2, 4'b0000, 1'b0, 4'b0000);
        drain();
        bus.sw = 4'b0001;
        push_n("pass_wait",  5, 4'b0000, 1'b0, 4'b0000);
        push_n("pass_press", 1, 4'b0000, 1'b0, 4'b0001);
        push_n("pass_led",   2, 4'b0001, 1'b1, 4'b0000);
        drain();
        bus.sw = 4'b0000;
        push_n("pass_rel", 6, 4'b0001, 1'b1, 4'b0000);
        push_n("pass_idle", 2, 4'b0000, 1'b0, 4'b0000);
        drain();

        // Glitch: 3-cycle pulse on sw[1] never commits
        bus.sw = 4'b0010;
        push_n("glitch_hi", 3, 4'b0000, 1'b0, 4'b0000);
        drain();
        bus.sw = 4'b0000;
        push_n("glitch_lo", 8, 4'b0000, 1'b0, 4'b0000);
        drain();

        // 4-cycle pulse on sw[1] is exactly long enough to commit
        bus.sw = 4'b0010;
        push_n("hold4_hi", 4, 4'b0000, 1'b0, 4'b0000);
        drain();
        bus.sw = 4'b0000;
        push_n("hold4_wait",  1, 4'b0000, 1'b0, 4'b0000);
        push_n("hold4_press", 1, 4'b0000, 1'b0, 4'b0010);
        push_n("hold4_led",   4, 4'b0010, 1'b1, 4'b0000);
        push_n("hold4_off",   2, 4'b0000, 1'b0, 4'b0000);
        drain();

        // TOGGLE on sw[2], tog cleared by reset first
        reset_pulse("rst_tog");
        bus.mode = 2'd1;
        bus.sw   = 4'b0100;
        push_n("tog1_wait",  5, 4'b0000, 1'b0, 4'b0000);
        push_n("tog1_press", 1, 4'b0000, 1'b0, 4'b0100);
        push_n("tog1_led",   2, 4'b0100, 1'b1, 4'b0000);
        drain();
        bus.sw = 4'b0000;
        push_n("tog1_rel",  6, 4'b0100, 1'b1, 4'b0000);
        push_n("tog1_relq", 2, 4'b0100, 1'b0, 4'b0000);
        drain();
        bus.mode = 2'd0;
        push_n("tog_m0", 2, 4'b0000, 1'b0, 4'b0000);
        drain();
        bus.mode = 2'd1;
        push_n("tog_m1", 2, 4'b0100, 1'b0, 4'b0000);
        drain();
        bus.sw = 4'b0100;
        push_n("tog2_wait",  5, 4'b0100, 1'b0, 4'b0000);
        push_n("tog2_press", 1, 4'b0100, 1'b0, 4'b0100);
        push_n("tog2_led",   2, 4'b0000, 1'b1, 4'b0000);
        drain();
        bus.sw = 4'b0000;
        push_n("tog2_rel",  6, 4'b0000, 1'b1, 4'b0000);
        push_n("tog2_relq", 2, 4'b0000, 1'b0, 4'b0000);
        drain();

        // BLINK: reset so phase starts at 0, sw[3] held high
        bus.sw   = 4'b1000;
        bus.mode = 2'd2;
        reset_pulse("rst_blink");
        for (int e = 1; e <= 18; e++) begin
            dbp = (e >= 7);
            ph  = ((e - 1) / BLINK_DIV) % 2;
            push_n("blink", 1, {dbp & (ph == 1), 3'b000}, dbp,
                   (e == 6) ? 4'b1000 : 4'b0000);
        end
        drain();

        // OR: sw[3] falls and sw[2] rises on the same commit edge
        bus.mode = 2'd3;
        bus.sw   = 4'b0100;
        push_n("or_wait",  5, 4'b1111, 1'b1, 4'b0000);
        push_n("or_press", 1, 4'b1111, 1'b1, 4'b0100);
        push_n("or_hold",  4, 4'b1111, 1'b1, 4'b0000);
        drain();
        bus.sw = 4'b0000;
        push_n("or_fall", 6, 4'b1111, 1'b1, 4'b0000);
        push_n("or_off",  2, 4'b0000, 1'b0, 4'b0000);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
